// File: rtl/fir_tdm_sequencer_if.sv
// rtl/fir_tdm_sequencer_if.sv - sample, result, coefficient and error-flag bundle of the TDM FIR engine
interface fir_tdm_sequencer_if #(
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_sample;
    logic          out_valid;
    logic [15:0]   out_sample;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [15:0]   coef_data;
    logic          clear_err;
    logic          overrun;
    logic          cfg_err;

    modport master (
        output in_valid, in_sample, coef_we, coef_addr, coef_data, clear_err,
        input  in_ready, out_valid, out_sample, overrun, cfg_err
    );

    modport slave (
        input  in_valid, in_sample, coef_we, coef_addr, coef_data, clear_err,
        output in_ready, out_valid, out_sample, overrun, cfg_err
    );
endinterface

// File: rtl/fir_tdm_sequencer.sv
// rtl/fir_tdm_sequencer.sv - single-MAC time-multiplexed FIR over a circular delay line
module fir_tdm_sequencer #(
    parameter int N_TAPS = 31,
    parameter int AW     = 5,
    parameter int ACC_W  = 40
) (
    input  logic                  sample_clock,
    input  logic                  reset,
    fir_tdm_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_t;

    localparam logic [AW-1:0]           LAST_TAP = AW'(N_TAPS - 1);
    localparam logic [AW-1:0]           NT_AW    = AW'(N_TAPS);
    localparam logic [AW:0]             NT_WIDE  = (AW + 1)'(N_TAPS);
    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(16384);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX - ACC_W'(1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           k_q, k_d;
    logic [AW-1:0]           wp_q, wp_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             out_sample_q, out_sample_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    cfg_err_q, cfg_err_d;

    logic signed [15:0]      x_q    [N_TAPS];
    logic signed [15:0]      coef_q [N_TAPS];

    logic                    ready_c;
    logic                    x_we;
    logic                    coef_we_ok;
    logic                    addr_ok;
    logic [AW-1:0]           tap_idx;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] rnd_sum;
    logic signed [ACC_W-1:0] rnd_shift;
    logic [15:0]             sat_val;

    // Datapath: newest-first tap addressing, product, rounding and saturation
    always_comb begin
        if (wp_q >= k_q) begin
            tap_idx = wp_q - k_q;
        end else begin
            tap_idx = wp_q + (NT_AW - k_q);
        end
        prod      = coef_q[k_q] * x_q[tap_idx];
        prod_ext  = {{(ACC_W - 32){prod[31]}}, prod};
        rnd_sum   = acc_q + HALF_LSB;
        rnd_shift = rnd_sum >>> 15;
        if (rnd_shift > SAT_MAX) begin
            sat_val = 16'h7fff;
        end else if (rnd_shift < SAT_MIN) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = rnd_shift[15:0];
        end
        addr_ok = ({1'b0, bus.coef_addr} < NT_WIDE);
    end

    // Next-state and control: IDLE accepts, MAC walks the taps, ROUND publishes
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        acc_d        = acc_q;
        wp_d         = wp_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        x_we         = 1'b0;
        coef_we_ok   = 1'b0;
        ready_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c    = 1'b1;
                coef_we_ok = bus.coef_we && addr_ok;
                if (bus.in_valid) begin
                    x_we    = 1'b1;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                if (k_q == LAST_TAP) begin
                    state_d = S_ROUND;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_ROUND: begin
                out_sample_d = sat_val;
                out_valid_d  = 1'b1;
                wp_d         = (wp_q == LAST_TAP) ? '0 : wp_q + 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A new set condition outranks a simultaneous clear
        overrun_d = (overrun_q & ~bus.clear_err) | (bus.in_valid & ~ready_c);
        cfg_err_d = (cfg_err_q & ~bus.clear_err) | (bus.coef_we & ~coef_we_ok);
    end

    // State register
    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer, accumulator, result and sticky flag registers
    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            k_q          <= '0;
            wp_q         <= '0;
            acc_q        <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            k_q          <= k_d;
            wp_q         <= wp_d;
            acc_q        <= acc_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Delay line and coefficient file; both are wiped by reset
    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (x_we) begin
                x_q[wp_q] <= bus.in_sample;
            end
            if (coef_we_ok) begin
                coef_q[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign bus.overrun    = overrun_q;
    assign bus.cfg_err    = cfg_err_q;
endmodule
